// File: rtl/mac_pkg.sv
// Shared types and default widths for the multiply-accumulate block.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mac_state_e;

  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned CNT_W_DEF  = 4;
  localparam int unsigned ACC_W_DEF  = 2 * DATA_W_DEF + CNT_W_DEF;

endpackage

// File: rtl/mac_multiplier.sv
// Combinational unsigned multiplier shared by the accumulator datapath.
module mac_multiplier #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic [2*W-1:0] M
);

  assign M = A * B;

endmodule

// File: rtl/mac_accumulator.sv
// Sums len unsigned products a*b, then holds the total until the consumer takes it.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc,
  output logic              busy
);

  mac_state_e          state_q, state_d;
  logic [CNT_W:0]      cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [2*DATA_W-1:0] prod;
  logic [CNT_W:0]      len_terms;

  mac_multiplier #(
    .W(DATA_W)
  ) u_mult (
    .A(a),
    .B(b),
    .M(prod)
  );

  // One extra counter bit so len=0 can stand for the full 2**CNT_W terms.
  assign len_terms = (len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, len};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = len_terms;
          state_d = RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = acc_q + ACC_W'(prod);
          cnt_d = cnt_q - (CNT_W+1)'(1);
          if (cnt_q == (CNT_W+1)'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  assign acc  = acc_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench: directed scenarios plus randomized transactions against a sum model.
module tb_mac_accumulator;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [11:0] acc;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: is a sum in progress, how many terms remain, is a result pending.
  int exp_sum   = 0;
  int remaining = 0;
  bit running   = 1'b0;
  bit pending   = 1'b0;

  mac_accumulator dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .len(len),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .acc(acc),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_sum   <= 0;
      remaining <= 0;
      running   <= 1'b0;
      pending   <= 1'b0;
    end else if (pending) begin
      if (out_ready) pending <= 1'b0;
    end else if (running) begin
      if (in_valid) begin
        exp_sum   <= exp_sum + int'(a) * int'(b);
        remaining <= remaining - 1;
        if (remaining == 1) begin
          running <= 1'b0;
          pending <= 1'b1;
        end
      end
    end else if (start) begin
      exp_sum   <= 0;
      remaining <= (len == 4'd0) ? 16 : int'(len);
      running   <= 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", int'(in_ready), int'(running));
    chk("out_valid", int'(out_valid), int'(pending));
    chk("busy", int'(busy), int'(running || pending));
    chk("acc", int'(acc), exp_sum);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int l);
    start = 1'b1;
    len   = 4'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input int x, input int y);
    in_valid = 1'b1;
    a        = 4'(x);
    b        = 4'(y);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int guard;
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("reset_acc", int'(acc), 0);
    chk("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick();

    // len=2: (10,10),(15,15) -> 325, valid right after the second accept
    do_start(2);
    beat(10, 10);
    chk("s1_not_done", int'(out_valid), 0);
    beat(15, 15);
    chk("s1_valid", int'(out_valid), 1);
    chk("s1_acc", int'(acc), 325);
    release_result();
    chk("s1_idle_busy", int'(busy), 0);
    chk("s1_idle_acc_hold", int'(acc), 325);

    // len=1: (15,0) -> 0
    do_start(1);
    beat(15, 0);
    chk("s2_valid", int'(out_valid), 1);
    chk("s2_acc", int'(acc), 0);
    release_result();
    chk("s2_idle", int'(busy), 0);

    // len=0 means 16 terms of (15,15) -> 3600
    do_start(0);
    for (int i = 0; i < 15; i++) beat(15, 15);
    chk("s3_early_valid", int'(out_valid), 0);
    beat(15, 15);
    chk("s3_valid", int'(out_valid), 1);
    chk("s3_acc", int'(acc), 3600);
    release_result();

    // len=3 with a gap, then a held-off consumer
    do_start(3);
    beat(11, 13);
    for (int i = 0; i < 4; i++) tick();
    chk("s4_gap_acc", int'(acc), 143);
    beat(15, 9);
    beat(9, 3);
    for (int i = 0; i < 5; i++) begin
      chk("s4_hold_acc", int'(acc), 305);
      chk("s4_in_ready", int'(in_ready), 0);
      tick();
    end
    release_result();

    // reset in the middle of a sum
    do_start(3);
    beat(7, 7);
    rst_n = 1'b0;
    #1;
    chk("s5_rst_acc", int'(acc), 0);
    chk("s5_rst_ready", int'(in_ready), 0);
    chk("s5_rst_busy", int'(busy), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("s5_idle", int'(busy), 0);
    do_start(1);
    beat(2, 3);
    chk("s5_acc", int'(acc), 6);
    release_result();

    // start ignored in RUN and DONE; start with out_ready in DONE only returns to IDLE
    do_start(2);
    beat(3, 4);
    start = 1'b1;
    len   = 4'd1;
    tick();
    start = 1'b0;
    chk("s6_run_acc", int'(acc), 12);
    chk("s6_run_ready", int'(in_ready), 1);
    beat(5, 5);
    chk("s6_two_terms", int'(out_valid), 1);
    start = 1'b1;
    tick();
    chk("s6_done_hold", int'(out_valid), 1);
    chk("s6_done_acc", int'(acc), 37);
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    chk("s6_no_capture", int'(busy), 0);
    tick();
    chk("s6_still_idle", int'(busy), 0);

    // randomized transactions
    for (int t = 0; t < 25; t++) begin
      do_start(int'($urandom_range(0, 15)));
      guard = 0;
      while (!out_valid && guard < 200) begin
        in_valid = 1'($urandom);
        a        = 4'($urandom);
        b        = 4'($urandom);
        start    = ($urandom_range(0, 7) == 0);
        tick();
        guard++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      if (!out_valid) chk("rand_done_timeout", 0, 1);
      guard = 0;
      while (out_valid && guard < 20) begin
        out_ready = 1'($urandom);
        start     = 1'($urandom);
        tick();
        guard++;
      end
      out_ready = 1'b0;
      start     = 1'b0;
      if (out_valid) release_result();
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
